mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multicycle control state machine that sequences the MIPS datapath over several clock cycles per instruction instead of one. It receives the opcode from the instruction register and drives every datapath select and enable: PC update, memory access, IR load, register write, and the ALU operation class for `AluControl`. It inserts wait states on a memory-ready handshake and traps on unsupported opcodes.

## Interface
- Parameters: none. State and opcode encodings come from the shared package.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `op`  in  6  opcode, `IR[31:26]`; sampled in DECODE only
- `mem_ready`  in  1  memory completes the current access this cycle
- `zero`  in  1  ALU zero flag
- `pc_write`  out  1  unconditional PC load
- `pc_write_cond`  out  1  PC load qualified by `zero`
- `pc_en`  out  1  `pc_write | (pc_write_cond & zero)`
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_read`, `mem_write`  out  1 each  memory strobes
- `ir_write`  out  1  instruction register load
- `mem_to_reg`  out  1  write-back select: 1 = MDR, 0 = ALUOut
- `reg_dst`  out  1  destination select: 1 = rd, 0 = rt
- `reg_write`  out  1  register file write
- `alu_src_a`  out  1  0 = PC, 1 = A
- `alu_src_b`  out  2  00 = B, 01 = 4, 10 = sign-ext, 11 = sign-ext<<2
- `alu_op`  out  3  000 = add, 001 = sub, 010 = use funct
- `pc_source`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `illegal_op`  out  1  sticky trap indication
- `state`  out  4  current state, for debug

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, TRAP.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=000, `pc_source`=00. `ir_write` and `pc_write` equal `mem_ready`. Go to DECODE when `mem_ready`=1; otherwise stay.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=000, which precomputes the branch target. Next state depends on `op`:
  - 100011 (lw) and 101011 (sw) → MEMADR
  - 000000 → EXEC
  - 001000 (addi) → ADDIEX
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - any other opcode → TRAP
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=000. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: `mem_read`=1, `i_or_d`=1. Go to MEMWB on `mem_ready`; otherwise stay.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Go to FETCH.
- MEMWR: `mem_write`=1, `i_or_d`=1. Go to FETCH on `mem_ready`; otherwise stay.
- EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=010. Go to ALUWB.
- ALUWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Go to FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=000. Go to ADDIWB.
- ADDIWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Go to FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=001, `pc_write_cond`=1, `pc_source`=01. Go to FETCH.
- JUMP: `pc_write`=1, `pc_source`=10. Go to FETCH.
- TRAP: all strobes 0, `illegal_op`=1. TRAP is absorbing; only `rst` leaves it.
- Any output not listed for a state is 0.

## Timing
- Outputs are combinational from the state register (Moore). The only exceptions are `ir_write`, `pc_write` and `pc_en` in FETCH, which are gated by `mem_ready`.
- While `rst`=1:
  - state is FETCH;
  - every output is forced to 0, including `pc_en` and `mem_read`;
  - `state` reads the FETCH encoding.
- After reset release, the first FETCH cycle is the first rising edge with `rst`=0.
- Cycles per instruction with `mem_ready` held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle `mem_ready` is low in FETCH, MEMRD or MEMWR adds one cycle. While waiting, outputs are held constant and there is no write-enable pulse.
- `rst` asserted mid-instruction aborts it immediately and asynchronously: no partial register or memory write completes after assertion.
- A `mem_ready` pulse in a state other than FETCH, MEMRD or MEMWR is ignored.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the 4-bit state encoding (FETCH=0 … TRAP=12);
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - `alu_op`, `alu_src_b` and `pc_source` encodings.
- Datapath muxes and `AluControl` import the same package.
- Module structure: a single module with a state register and next-state/output combinational logic. No sub-module.

## Test plan
- Reset: assert `rst` mid-MEMRD → `state`=0 and all outputs 0 in the same cycle. Release with `op`=000000 and `mem_ready`=1 → sequence FETCH, DECODE, EXEC, ALUWB, FETCH; `reg_write`=1 only in ALUWB with `reg_dst`=1.
- lw with `mem_ready` low for 2 cycles in MEMRD → 7 cycles total, one `reg_write` pulse with `mem_to_reg`=1, `mem_read` held for all 3 MEMRD cycles.
- sw with `mem_ready`=1 → 4 cycles, `mem_write`=1 for exactly 1 cycle with `i_or_d`=1, and `reg_write` never asserted.
- beq with `zero`=1 → `pc_en`=1 in BRANCH with `pc_source`=01. The same instruction with `zero`=0 → `pc_en`=0 and return to FETCH.
- j → JUMP asserts `pc_write`=1 with `pc_source`=10, 3 cycles total. addi → ADDIEX/ADDIWB with `alu_src_b`=10 and `reg_dst`=0.
- `op`=111111 in DECODE → TRAP with `illegal_op`=1 held for 20 cycles and no strobes. `rst` pulse → `illegal_op`=0 and state returns to FETCH.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: state numbering, opcodes,
// datapath select codes and the bundle of control strobes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_ADDIEX = 4'd8,
        ST_ADDIWB = 4'd9,
        ST_BRANCH = 4'd10,
        ST_JUMP   = 4'd11,
        ST_TRAP   = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    // Opcode dispatch out of DECODE; anything unsupported lands in TRAP.
    function automatic state_e decode_next(input logic [5:0] opcode);
        case (opcode)
            OP_LW, OP_SW: return ST_MEMADR;
            OP_RTYPE:     return ST_EXEC;
            OP_ADDI:      return ST_ADDIEX;
            OP_BEQ:       return ST_BRANCH;
            OP_J:         return ST_JUMP;
            default:      return ST_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// and drives every datapath select, with memory wait states and an illegal-op trap.
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       mem_ready,
    input  logic       zero,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_e state_q, state_d;
    logic   is_lw_q, is_lw_d;
    ctrl_t  ctrl;

    // The opcode is only valid in DECODE, so the lw/sw choice is latched there
    // for MEMADR to use one cycle later.
    always_comb begin
        state_d = state_q;
        is_lw_d = is_lw_q;
        case (state_q)
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                is_lw_d = (op == OP_LW);
                state_d = decode_next(op);
            end
            ST_MEMADR: state_d = is_lw_q ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  if (mem_ready) state_d = ST_MEMWB;
            ST_MEMWR:  if (mem_ready) state_d = ST_FETCH;
            ST_EXEC:   state_d = ST_ALUWB;
            ST_ADDIEX: state_d = ST_ADDIWB;
            ST_MEMWB,
            ST_ALUWB,
            ST_ADDIWB,
            ST_BRANCH,
            ST_JUMP:   state_d = ST_FETCH;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_TRAP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            is_lw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_lw_q <= is_lw_d;
        end
    end

    // Moore decode of the state; FETCH's IR/PC loads wait for mem_ready so a
    // stalled fetch never pulses a write enable.
    always_comb begin
        ctrl = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_MEMADR, ST_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            ST_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            ST_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ST_ADDIWB: ctrl.reg_write = 1'b1;
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            ST_TRAP:  ctrl.illegal_op = 1'b1;
            default:  ctrl = '0;
        endcase
        if (rst) ctrl = '0;
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_en         = ctrl.pc_write | (ctrl.pc_write_cond & zero);
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign illegal_op    = ctrl.illegal_op;
    assign state         = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed vector table, hand-written multi-cycle
// sequences, then random opcodes/handshakes against an instruction-phase model.
module tb_mc_control_fsm;

    logic       clk, rst, mem_ready, zero;
    logic [5:0] op;
    logic       pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;

    mc_control_fsm dut (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready), .zero(zero),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_en(pc_en),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op),
        .state(state)
    );

    // {state, pc_en, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op}
    logic [22:0] dut_vec;
    assign dut_vec = {state, pc_en, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                      ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                      alu_op, pc_source, illegal_op};

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

    int tests = 0;
    int failed = 0;
    logic [22:0] exp_q[$];
    logic [17:0] ctrl_tab [13];
    int prog[$];
    logic [5:0] legal_ops [6] = '{LW, SW, RT, BEQ, JMP, ADDI};

    typedef struct {
        logic [5:0] op;
        logic       mr;
        logic       z;
        logic [3:0] st;
        logic       pc_en;
        logic       rw;
        logic       mw;
        logic [1:0] ps;
        logic [1:0] asb;
        logic       rd;
    } vec_t;
    vec_t vecs[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [5:0] o, input logic mr, input logic z);
        op = o;
        mem_ready = mr;
        zero = z;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [5:0] o, input logic mr, input logic z,
                           input logic [3:0] st, input logic pe, input logic rw,
                           input logic mw, input logic [1:0] ps, input logic [1:0] asb,
                           input logic rd);
        vec_t v;
        v.op = o; v.mr = mr; v.z = z; v.st = st; v.pc_en = pe;
        v.rw = rw; v.mw = mw; v.ps = ps; v.asb = asb; v.rd = rd;
        vecs.push_back(v);
    endtask

    function automatic logic [17:0] mk(input logic pw, input logic pwc, input logic iord,
                                       input logic mrd, input logic mwr, input logic irw,
                                       input logic m2r, input logic rd, input logic rw,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [2:0] aop, input logic [1:0] ps,
                                       input logic ill);
        return {pw, pwc, iord, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, ps, ill};
    endfunction

    // Expected outputs of a phase; FETCH's IR/PC loads follow mem_ready.
    function automatic logic [22:0] exp_vec(input int ph, input logic mr, input logic z);
        logic [17:0] c;
        logic [3:0]  s;
        c = ctrl_tab[ph];
        s = 4'(ph);
        if (ph == 0) begin
            c[17] = mr;
            c[12] = mr;
        end
        return {s, c[17] | (c[16] & z), c};
    endfunction

    // Instruction-level model: prog holds the remaining phases of the current instruction.
    task automatic model_step(input logic [5:0] o, input logic mr);
        int ph;
        ph = prog[0];
        if (ph == 12) begin
        end else if ((ph == 0 || ph == 3 || ph == 5) && !mr) begin
        end else if (ph == 0) begin
            prog = '{1};
        end else if (ph == 1) begin
            case (o)
                LW:      prog = '{2, 3, 4};
                SW:      prog = '{2, 5};
                RT:      prog = '{6, 7};
                ADDI:    prog = '{8, 9};
                BEQ:     prog = '{10};
                JMP:     prog = '{11};
                default: prog = '{12};
            endcase
        end else begin
            prog.delete(0);
            if (prog.size() == 0) prog = '{0};
        end
    endtask

    initial begin
        int cyc, rw_pulses, m2r_bad, rd_cycles, waits, trap_cnt;
        logic done, mr_r, z_r, do_rst;
        logic [5:0] o;
        logic [3:0] rt_states [5];

        ctrl_tab[0]  = mk(0,0,0,1,0,0,0,0,0,0,2'b01,3'b000,2'b00,0);
        ctrl_tab[1]  = mk(0,0,0,0,0,0,0,0,0,0,2'b11,3'b000,2'b00,0);
        ctrl_tab[2]  = mk(0,0,0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0);
        ctrl_tab[3]  = mk(0,0,1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0);
        ctrl_tab[4]  = mk(0,0,0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0);
        ctrl_tab[5]  = mk(0,0,1,0,1,0,0,0,0,0,2'b00,3'b000,2'b00,0);
        ctrl_tab[6]  = mk(0,0,0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0);
        ctrl_tab[7]  = mk(0,0,0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0);
        ctrl_tab[8]  = mk(0,0,0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0);
        ctrl_tab[9]  = mk(0,0,0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0);
        ctrl_tab[10] = mk(0,1,0,0,0,0,0,0,0,1,2'b00,3'b001,2'b01,0);
        ctrl_tab[11] = mk(1,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,0);
        ctrl_tab[12] = mk(0,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,1);

        //       op   mr z  st pe rw mw ps asb rd
        add_vec(SW,   1, 0, 0, 1, 0, 0, 0, 1, 0);
        add_vec(SW,   1, 0, 1, 0, 0, 0, 0, 3, 0);
        add_vec(SW,   1, 0, 2, 0, 0, 0, 0, 2, 0);
        add_vec(SW,   1, 0, 5, 0, 0, 1, 0, 0, 0);
        add_vec(BEQ,  1, 1, 0, 1, 0, 0, 0, 1, 0);
        add_vec(BEQ,  1, 1, 1, 0, 0, 0, 0, 3, 0);
        add_vec(BEQ,  1, 1, 10, 1, 0, 0, 1, 0, 0);
        add_vec(BEQ,  1, 0, 0, 1, 0, 0, 0, 1, 0);
        add_vec(BEQ,  1, 0, 1, 0, 0, 0, 0, 3, 0);
        add_vec(BEQ,  1, 0, 10, 0, 0, 0, 1, 0, 0);
        add_vec(JMP,  1, 0, 0, 1, 0, 0, 0, 1, 0);
        add_vec(JMP,  1, 0, 1, 0, 0, 0, 0, 3, 0);
        add_vec(JMP,  1, 0, 11, 1, 0, 0, 2, 0, 0);
        add_vec(ADDI, 1, 0, 0, 1, 0, 0, 0, 1, 0);
        add_vec(ADDI, 1, 0, 1, 0, 0, 0, 0, 3, 0);
        add_vec(ADDI, 1, 0, 8, 0, 0, 0, 0, 2, 0);
        add_vec(ADDI, 1, 0, 9, 0, 1, 0, 0, 0, 0);
        add_vec(ADDI, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Reset
        rst = 1'b1;
        op = 6'd0; mem_ready = 1'b1; zero = 1'b1;
        step(); step();
        check("reset_state", dut_vec, 23'd0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].op, vecs[i].mr, vecs[i].z);
            check($sformatf("vec%0d", i),
                  {state, pc_en, reg_write, mem_write, pc_source, alu_src_b, reg_dst},
                  {vecs[i].st, vecs[i].pc_en, vecs[i].rw, vecs[i].mw, vecs[i].ps,
                   vecs[i].asb, vecs[i].rd});
            step();
        end

        // Reset asserted mid-MEMRD, then an R-type after release
        drive(LW, 1, 0); step();
        drive(LW, 1, 0); step();
        drive(LW, 1, 0); step();
        drive(LW, 0, 0);
        check("memrd_before_rst", {state, mem_read, i_or_d}, {4'd3, 1'b1, 1'b1});
        rst = 1'b1;
        #1;
        check("rst_async", dut_vec, 23'd0);
        step();
        check("rst_hold", dut_vec, 23'd0);
        rst = 1'b0;
        rt_states = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        for (int k = 0; k < 5; k++) begin
            drive(RT, 1, 0);
            check($sformatf("rtype_c%0d", k), {state, reg_write, reg_dst},
                  {rt_states[k], (k == 3), (k == 3)});
            if (k < 4) step();
        end

        // lw with two MEMRD wait cycles
        cyc = 0; rw_pulses = 0; m2r_bad = 0; rd_cycles = 0; waits = 0; done = 1'b0;
        while (!done && cyc < 20) begin
            mr_r = 1'b1;
            if (state == 4'd3 && waits < 2) begin
                mr_r = 1'b0;
                waits++;
            end
            drive(LW, mr_r, 0);
            if (reg_write) begin
                rw_pulses++;
                if (!mem_to_reg) m2r_bad++;
            end
            if (state == 4'd3 && mem_read) rd_cycles++;
            cyc++;
            step();
            if (state == 4'd0) done = 1'b1;
        end
        check("lw_wait_cycles", cyc, 7);
        check("lw_reg_write_pulses", rw_pulses, 1);
        check("lw_mem_to_reg", m2r_bad, 0);
        check("lw_mem_read_cycles", rd_cycles, 3);

        // Illegal opcode trap, then reset pulse
        drive(6'h3f, 1, 0); step();
        drive(6'h3f, 1, 0); step();
        for (int k = 0; k < 20; k++) begin
            drive(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check($sformatf("trap_hold%0d", k), dut_vec, exp_vec(12, mem_ready, zero));
            step();
        end
        rst = 1'b1;
        #1;
        check("trap_rst", {state, illegal_op}, 5'd0);
        rst = 1'b0;
        #1;
        check("trap_rst_release", dut_vec, exp_vec(0, mem_ready, zero));

        // Random opcodes, handshakes, zero flags and occasional resets
        prog = '{0};
        trap_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) o = 6'($urandom_range(0, 63));
            else o = legal_ops[$urandom_range(0, 5)];
            mr_r = ($urandom_range(0, 3) != 0);
            z_r = 1'($urandom_range(0, 1));
            drive(o, mr_r, z_r);
            exp_q.push_back(exp_vec(prog[0], mr_r, z_r));
            check($sformatf("rand%0d", n), dut_vec, exp_q.pop_front());
            if (prog[0] == 12) trap_cnt++;
            do_rst = (trap_cnt > 3) || ($urandom_range(0, 99) == 0);
            if (do_rst) begin
                rst = 1'b1;
                #1;
                check($sformatf("rand_rst%0d", n), dut_vec, 23'd0);
                rst = 1'b0;
                prog = '{0};
                trap_cnt = 0;
            end
            model_step(o, mr_r);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
